// File: rtl/fx_master.sv
// fx_master: command-driven burst master for the fx register bus (write/read bursts, RD_LAT read pipe).
// Optional beat statistics counters are built only when FX_MASTER_STAT_EN is defined.
module fx_master #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_last,
    output logic        busy,
    output logic [15:0] fx_waddr,
    output logic        fx_wr,
    output logic [7:0]  fx_data,
    output logic [15:0] fx_raddr,
    output logic        fx_rd,
    input  logic [7:0]  fx_q,
    output logic [15:0] stat_wr_cnt,
    output logic [15:0] stat_rd_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        beat_q, beat_d;
    logic              fx_wr_q, fx_wr_d;
    logic [7:0]        fx_data_q, fx_data_d;
    logic [15:0]       fx_waddr_q, fx_waddr_d;
    logic [15:0]       raddr_hold_q, raddr_hold_d;
    logic [RD_LAT-1:0] pv_q, pv_d;
    logic [RD_LAT-1:0] pl_q, pl_d;
    logic [15:0]       beat_addr;
    logic              last_beat;

    // Low byte wraps within the page; high byte stays fixed for the whole burst.
    always_comb begin
        beat_addr = {addr_q[15:8], addr_q[7:0] + beat_q};
        last_beat = (beat_q == len_q);
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign wr_ready  = (state_q == S_WRITE);
    assign fx_rd     = (state_q == S_READ);
    assign fx_wr     = fx_wr_q;
    assign fx_data   = fx_data_q;
    assign fx_waddr  = fx_waddr_q;
    // Read address is live during READ and otherwise shows the last issued address.
    assign fx_raddr  = fx_rd ? beat_addr : raddr_hold_q;
    assign rsp_valid = pv_q[RD_LAT-1];
    assign rsp_last  = pl_q[RD_LAT-1];
    assign rsp_data  = rsp_valid ? fx_q : '0;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        beat_d       = beat_q;
        fx_wr_d      = 1'b0;
        fx_data_d    = fx_data_q;
        fx_waddr_d   = fx_waddr_q;
        raddr_hold_d = raddr_hold_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    beat_d  = '0;
                    state_d = cmd_rd ? S_READ : S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_valid) begin
                    fx_wr_d    = 1'b1;
                    fx_data_d  = wr_data;
                    fx_waddr_d = beat_addr;
                    if (last_beat) state_d = S_IDLE;
                    else           beat_d  = beat_q + 8'd1;
                end
            end
            S_READ: begin
                raddr_hold_d = beat_addr;
                if (last_beat) state_d = S_DRAIN;
                else           beat_d  = beat_q + 8'd1;
            end
            default: begin
                if (rsp_last) state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pv_d    = pv_q;
        pl_d    = pl_q;
        pv_d[0] = fx_rd;
        pl_d[0] = fx_rd && last_beat;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pl_d[i] = pl_q[i-1];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            fx_wr_q      <= 1'b0;
            fx_data_q    <= '0;
            fx_waddr_q   <= '0;
            raddr_hold_q <= '0;
            pv_q         <= '0;
            pl_q         <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            fx_wr_q      <= fx_wr_d;
            fx_data_q    <= fx_data_d;
            fx_waddr_q   <= fx_waddr_d;
            raddr_hold_q <= raddr_hold_d;
            pv_q         <= pv_d;
            pl_q         <= pl_d;
        end
    end

`ifdef FX_MASTER_STAT_EN
    logic [15:0] stat_wr_q, stat_wr_d;
    logic [15:0] stat_rd_q, stat_rd_d;

    always_comb begin
        stat_wr_d = stat_wr_q;
        stat_rd_d = stat_rd_q;
        if (fx_wr_q && (stat_wr_q != 16'hFFFF))   stat_wr_d = stat_wr_q + 16'd1;
        if (rsp_valid && (stat_rd_q != 16'hFFFF)) stat_rd_d = stat_rd_q + 16'd1;
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
        end else begin
            stat_wr_q <= stat_wr_d;
            stat_rd_q <= stat_rd_d;
        end
    end

    assign stat_wr_cnt = stat_wr_q;
    assign stat_rd_cnt = stat_rd_q;
`else
    assign stat_wr_cnt = '0;
    assign stat_rd_cnt = '0;
`endif

endmodule

// File: tb/tb_fx_master.sv
// Directed bench for fx_master: one RD_LAT=1 and one RD_LAT=3 instance, each with a latency-matched slave model.
module tb_fx_master;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic rst;
    int   checks;
    int   errors;

`ifdef FX_MASTER_STAT_EN
    localparam logic [15:0] EXP_SWR = 16'd3;
    localparam logic [15:0] EXP_SRD = 16'd5;
`else
    localparam logic [15:0] EXP_SWR = 16'd0;
    localparam logic [15:0] EXP_SRD = 16'd0;
`endif

    logic        cmd_valid_a, cmd_ready_a, cmd_rd_a, wr_valid_a, wr_ready_a;
    logic [15:0] cmd_addr_a;
    logic [7:0]  cmd_len_a, wr_data_a, rsp_data_a, fx_data_a, fx_q_a;
    logic        rsp_valid_a, rsp_last_a, busy_a, fx_wr_a, fx_rd_a;
    logic [15:0] fx_waddr_a, fx_raddr_a, stat_wr_a, stat_rd_a;

    logic        cmd_valid_b, cmd_ready_b, cmd_rd_b, wr_valid_b, wr_ready_b;
    logic [15:0] cmd_addr_b;
    logic [7:0]  cmd_len_b, wr_data_b, rsp_data_b, fx_data_b, fx_q_b;
    logic        rsp_valid_b, rsp_last_b, busy_b, fx_wr_b, fx_rd_b;
    logic [15:0] fx_waddr_b, fx_raddr_b, stat_wr_b, stat_rd_b;

    fx_master #(.RD_LAT(1)) u_a (
        .clk_sys(clk_sys), .rst(rst),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_rd(cmd_rd_a),
        .cmd_addr(cmd_addr_a), .cmd_len(cmd_len_a),
        .wr_valid(wr_valid_a), .wr_ready(wr_ready_a), .wr_data(wr_data_a),
        .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .rsp_last(rsp_last_a),
        .busy(busy_a), .fx_waddr(fx_waddr_a), .fx_wr(fx_wr_a), .fx_data(fx_data_a),
        .fx_raddr(fx_raddr_a), .fx_rd(fx_rd_a), .fx_q(fx_q_a),
        .stat_wr_cnt(stat_wr_a), .stat_rd_cnt(stat_rd_a)
    );

    fx_master #(.RD_LAT(3)) u_b (
        .clk_sys(clk_sys), .rst(rst),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_rd(cmd_rd_b),
        .cmd_addr(cmd_addr_b), .cmd_len(cmd_len_b),
        .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .wr_data(wr_data_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_last(rsp_last_b),
        .busy(busy_b), .fx_waddr(fx_waddr_b), .fx_wr(fx_wr_b), .fx_data(fx_data_b),
        .fx_raddr(fx_raddr_b), .fx_rd(fx_rd_b), .fx_q(fx_q_b),
        .stat_wr_cnt(stat_wr_b), .stat_rd_cnt(stat_rd_b)
    );

    // Slaves return the low address byte as data, RD_LAT cycles after the strobe.
    logic [7:0] sa_q;
    logic [7:0] sb_q [3];
    always @(posedge clk_sys) begin
        sa_q     <= fx_rd_a ? fx_raddr_a[7:0] : 8'h00;
        sb_q[0]  <= fx_rd_b ? fx_raddr_b[7:0] : 8'h00;
        sb_q[1]  <= sb_q[0];
        sb_q[2]  <= sb_q[1];
    end
    assign fx_q_a = sa_q;
    assign fx_q_b = sb_q[2];

    // Gapped write burst at 0x03FE, one entry per cycle after command accept.
    int          t_wv    [7] = '{1, 1, 0, 0, 1, 1, 0};
    logic [7:0]  t_wd    [7] = '{8'h10, 8'h11, 8'h00, 8'h00, 8'h12, 8'h13, 8'h00};
    logic        t_wr    [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] t_waddr [7] = '{16'h0510, 16'h03FE, 16'h03FF, 16'h03FF, 16'h03FF, 16'h0300, 16'h0301};
    logic [7:0]  t_wdat  [7] = '{8'hA5, 8'h10, 8'h11, 8'h11, 8'h11, 8'h12, 8'h13};
    logic        t_wbusy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // RD_LAT=3 read of two beats at 0x0740.
    logic        t_brd   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] t_braddr[6] = '{16'h0740, 16'h0741, 16'h0741, 16'h0741, 16'h0741, 16'h0741};
    logic        t_brv   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0]  t_brdat [6] = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h41, 8'h00};
    logic        t_brl   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        t_bcr   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_cmd_ready"}, {15'd0, cmd_ready_a}, 16'd1);
        chk({tag, "_busy"},      {15'd0, busy_a},      16'd0);
        chk({tag, "_wr_ready"},  {15'd0, wr_ready_a},  16'd0);
        chk({tag, "_fx_wr"},     {15'd0, fx_wr_a},     16'd0);
        chk({tag, "_fx_rd"},     {15'd0, fx_rd_a},     16'd0);
        chk({tag, "_fx_waddr"},  fx_waddr_a,           16'd0);
        chk({tag, "_fx_raddr"},  fx_raddr_a,           16'd0);
        chk({tag, "_fx_data"},   {8'd0, fx_data_a},    16'd0);
        chk({tag, "_rsp_valid"}, {15'd0, rsp_valid_a}, 16'd0);
        chk({tag, "_rsp_data"},  {8'd0, rsp_data_a},   16'd0);
        chk({tag, "_rsp_last"},  {15'd0, rsp_last_a},  16'd0);
        chk({tag, "_stat_wr"},   stat_wr_a,            16'd0);
        chk({tag, "_stat_rd"},   stat_rd_a,            16'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        cmd_valid_a = 0; cmd_rd_a = 0; cmd_addr_a = '0; cmd_len_a = '0; wr_valid_a = 0; wr_data_a = '0;
        cmd_valid_b = 0; cmd_rd_b = 0; cmd_addr_b = '0; cmd_len_b = '0; wr_valid_b = 0; wr_data_b = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_idle_a("reset");
        chk("reset_b_cmd_ready", {15'd0, cmd_ready_b}, 16'd1);
        chk("reset_b_rsp_valid", {15'd0, rsp_valid_b}, 16'd0);

        // Single-beat write.
        cmd_valid_a = 1; cmd_rd_a = 0; cmd_addr_a = 16'h0510; cmd_len_a = 8'd0;
        tick();
        chk("w1_busy", {15'd0, busy_a}, 16'd1);
        chk("w1_cmd_ready", {15'd0, cmd_ready_a}, 16'd0);
        chk("w1_wr_ready", {15'd0, wr_ready_a}, 16'd1);
        cmd_valid_a = 0; wr_valid_a = 1; wr_data_a = 8'hA5;
        tick();
        chk("w1_fx_wr", {15'd0, fx_wr_a}, 16'd1);
        chk("w1_fx_waddr", fx_waddr_a, 16'h0510);
        chk("w1_fx_data", {8'd0, fx_data_a}, 16'h00A5);
        chk("w1_fx_rd", {15'd0, fx_rd_a}, 16'd0);
        wr_valid_a = 0;
        tick();
        chk("w1_after_fx_wr", {15'd0, fx_wr_a}, 16'd0);
        chk("w1_after_cmd_ready", {15'd0, cmd_ready_a}, 16'd1);
        chk("w1_hold_waddr", fx_waddr_a, 16'h0510);
        chk("w1_hold_data", {8'd0, fx_data_a}, 16'h00A5);

        // Eight-beat read, RD_LAT=1.
        cmd_valid_a = 1; cmd_rd_a = 1; cmd_addr_a = 16'h0580; cmd_len_a = 8'd7;
        tick();
        cmd_valid_a = 0;
        for (int i = 0; i < 9; i++) begin
            chk("r8_fx_rd", {15'd0, fx_rd_a}, (i < 8) ? 16'd1 : 16'd0);
            if (i < 8) chk("r8_fx_raddr", fx_raddr_a, 16'h0580 + 16'(i));
            chk("r8_fx_wr", {15'd0, fx_wr_a}, 16'd0);
            chk("r8_rsp_valid", {15'd0, rsp_valid_a}, (i > 0) ? 16'd1 : 16'd0);
            chk("r8_rsp_data", {8'd0, rsp_data_a}, (i > 0) ? 16'h007F + 16'(i) : 16'd0);
            chk("r8_rsp_last", {15'd0, rsp_last_a}, (i == 8) ? 16'd1 : 16'd0);
            chk("r8_cmd_ready", {15'd0, cmd_ready_a}, 16'd0);
            tick();
        end
        chk("r8_done_cmd_ready", {15'd0, cmd_ready_a}, 16'd1);
        chk("r8_done_rsp_valid", {15'd0, rsp_valid_a}, 16'd0);
        chk("r8_done_rsp_data", {8'd0, rsp_data_a}, 16'd0);
        chk("r8_hold_raddr", fx_raddr_a, 16'h0587);

        // Four-beat write with a wr_valid gap and low-byte wrap.
        cmd_valid_a = 1; cmd_rd_a = 0; cmd_addr_a = 16'h03FE; cmd_len_a = 8'd3;
        tick();
        cmd_valid_a = 0;
        for (int c = 0; c < 7; c++) begin
            wr_valid_a = (t_wv[c] != 0);
            wr_data_a  = t_wd[c];
            chk("wg_fx_wr", {15'd0, fx_wr_a}, {15'd0, t_wr[c]});
            chk("wg_fx_waddr", fx_waddr_a, t_waddr[c]);
            chk("wg_fx_data", {8'd0, fx_data_a}, {8'd0, t_wdat[c]});
            chk("wg_busy", {15'd0, busy_a}, {15'd0, t_wbusy[c]});
            chk("wg_fx_rd", {15'd0, fx_rd_a}, 16'd0);
            tick();
        end
        wr_valid_a = 0;
        chk("wg_end_fx_wr", {15'd0, fx_wr_a}, 16'd0);
        chk("wg_end_cmd_ready", {15'd0, cmd_ready_a}, 16'd1);

        // RD_LAT=3 two-beat read.
        cmd_valid_b = 1; cmd_rd_b = 1; cmd_addr_b = 16'h0740; cmd_len_b = 8'd1;
        tick();
        cmd_valid_b = 0;
        for (int c = 0; c < 6; c++) begin
            chk("l3_fx_rd", {15'd0, fx_rd_b}, {15'd0, t_brd[c]});
            chk("l3_fx_raddr", fx_raddr_b, t_braddr[c]);
            chk("l3_rsp_valid", {15'd0, rsp_valid_b}, {15'd0, t_brv[c]});
            chk("l3_rsp_data", {8'd0, rsp_data_b}, {8'd0, t_brdat[c]});
            chk("l3_rsp_last", {15'd0, rsp_last_b}, {15'd0, t_brl[c]});
            chk("l3_cmd_ready", {15'd0, cmd_ready_b}, {15'd0, t_bcr[c]});
            tick();
        end

        // Reset during beat 4 of a sixteen-beat read.
        cmd_valid_a = 1; cmd_rd_a = 1; cmd_addr_a = 16'h0600; cmd_len_a = 8'd15;
        tick();
        cmd_valid_a = 0;
        for (int i = 0; i < 4; i++) begin
            chk("rr_fx_raddr", fx_raddr_a, 16'h0600 + 16'(i));
            tick();
        end
        chk("rr_beat4_fx_rd", {15'd0, fx_rd_a}, 16'd1);
        chk("rr_beat4_fx_raddr", fx_raddr_a, 16'h0604);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_a("rr_after_rst");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_no_rsp", {15'd0, rsp_valid_a}, 16'd0);
            chk("rr_no_fx_rd", {15'd0, fx_rd_a}, 16'd0);
            chk("rr_no_fx_wr", {15'd0, fx_wr_a}, 16'd0);
            chk("rr_cmd_ready", {15'd0, cmd_ready_a}, 16'd1);
        end

        // Statistics: three write beats then five read beats.
        cmd_valid_a = 1; cmd_rd_a = 0; cmd_addr_a = 16'h0100; cmd_len_a = 8'd2;
        tick();
        cmd_valid_a = 0;
        wr_valid_a = 1;
        for (int i = 0; i < 3; i++) begin
            wr_data_a = 8'(8'h20 + i);
            tick();
        end
        wr_valid_a = 0;
        tick();
        chk("st_write_done", {15'd0, cmd_ready_a}, 16'd1);
        cmd_valid_a = 1; cmd_rd_a = 1; cmd_addr_a = 16'h0200; cmd_len_a = 8'd4;
        tick();
        cmd_valid_a = 0;
        for (int k = 0; k < 20 && !cmd_ready_a; k++) tick();
        chk("st_read_done", {15'd0, cmd_ready_a}, 16'd1);
        tick();
        chk("st_wr_cnt", stat_wr_a, EXP_SWR);
        chk("st_rd_cnt", stat_rd_a, EXP_SRD);
        chk("st_b_wr_cnt", stat_wr_b, 16'd0);
        chk("st_b_rd_cnt", stat_rd_b, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
